// File: rtl/wir_sel_ctrl_if.sv
// WSP-side wrapper-instruction bus for wir_sel_ctrl.
// Carries parity_err only when WIR_PARITY_EN is defined.
interface wir_sel_ctrl_if #(
    parameter int NUM_MUX = 8,
    parameter int WIR_LEN = 3
);
    logic               wsi;
    logic               select_wir;
    logic               capture_wr;
    logic               shift_wr;
    logic               update_wr;
    logic               wso_wir;
    logic [WIR_LEN-1:0] instr;
    logic [NUM_MUX-1:0] mux_sel;
    logic               se;
    logic               he;
    logic               busy;
`ifdef WIR_PARITY_EN
    logic               parity_err;

    modport master (
        output wsi, select_wir, capture_wr, shift_wr, update_wr,
        input  wso_wir, instr, mux_sel, se, he, busy, parity_err
    );
    modport slave (
        input  wsi, select_wir, capture_wr, shift_wr, update_wr,
        output wso_wir, instr, mux_sel, se, he, busy, parity_err
    );
`else
    modport master (
        output wsi, select_wir, capture_wr, shift_wr, update_wr,
        input  wso_wir, instr, mux_sel, se, he, busy
    );
    modport slave (
        input  wsi, select_wir, capture_wr, shift_wr, update_wr,
        output wso_wir, instr, mux_sel, se, he, busy
    );
`endif
endinterface

// File: rtl/wir_sel_ctrl.sv
// IEEE 1500 WIR controller: serial WIR, registered mux/SE/HE decode, safe-state sequencer.
// Optional feature: WIR_PARITY_EN adds an odd-parity bit to the WIR and a parity_err pulse.
module wir_sel_ctrl #(
    parameter int                 NUM_MUX  = 8,
    parameter int                 WIR_LEN  = 3,
    parameter logic [NUM_MUX-1:0] WPC_MASK = NUM_MUX'(8'b0011_1000),
    parameter int                 SAFE_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    wir_sel_ctrl_if.slave bus
);

`ifdef WIR_PARITY_EN
    localparam int SRW = WIR_LEN + 1;
`else
    localparam int SRW = WIR_LEN;
`endif

    localparam logic [WIR_LEN-1:0] OP_WPC    = WIR_LEN'(1);
    localparam logic [WIR_LEN-1:0] OP_EXTEST = WIR_LEN'(2);
    localparam logic [WIR_LEN-1:0] OP_INTEST = WIR_LEN'(3);
    localparam logic [3:0]         CNT_INIT  = 4'(SAFE_CYC - 1);

    typedef enum logic {ACTIVE, SAFE} state_e;

    typedef struct packed {
        logic [NUM_MUX-1:0] mux;
        logic               se;
        logic               he;
    } dec_t;

    localparam dec_t DEC_BYP = '{mux: '0, se: 1'b0, he: 1'b1};

    function automatic dec_t decode(input logic [WIR_LEN-1:0] op);
        dec_t d;
        d = DEC_BYP;
        unique case (1'b1)
            (op == OP_WPC):    d = '{mux: WPC_MASK, se: 1'b1, he: 1'b0};
            (op == OP_EXTEST): d = '{mux: '1, se: 1'b0, he: 1'b1};
            (op == OP_INTEST): d = '{mux: '1, se: 1'b1, he: 1'b0};
            default:           d = DEC_BYP;
        endcase
        return d;
    endfunction

    logic [SRW-1:0]     sr_q, sr_d, cap_val;
    logic [WIR_LEN-1:0] instr_q, op;
    state_e             state_q;
    logic [3:0]         cnt_q;
    dec_t               out_q, dec_op, dec_act;
    logic               busy_q, perr_q;
    logic               upd_en, par_ok, load;

    assign op = sr_q[WIR_LEN-1:0];

`ifdef WIR_PARITY_EN
    assign par_ok  = ^sr_q;
    assign cap_val = {~^instr_q, instr_q};
`else
    assign par_ok  = 1'b1;
    assign cap_val = instr_q;
`endif

    assign upd_en  = bus.select_wir & bus.update_wr;
    assign load    = upd_en & par_ok & (op != instr_q);
    assign dec_op  = decode(op);
    assign dec_act = decode(instr_q);

    // Capture wins over shift; update always sees the pre-edge shift stage.
    always_comb begin
        sr_d = sr_q;
        if (bus.select_wir) begin
            if (bus.capture_wr)
                sr_d = cap_val;
            else if (bus.shift_wr)
                sr_d = {bus.wsi, sr_q[SRW-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            instr_q <= '0;
            state_q <= ACTIVE;
            cnt_q   <= '0;
            out_q   <= DEC_BYP;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            perr_q <= upd_en & ~par_ok;
            if (load) begin
                instr_q <= op;
                if (SAFE_CYC == 0) begin
                    state_q <= ACTIVE;
                    out_q   <= dec_op;
                    busy_q  <= 1'b0;
                end else begin
                    // counter holds remaining safe cycles minus one
                    state_q <= SAFE;
                    cnt_q   <= CNT_INIT;
                    out_q   <= DEC_BYP;
                    busy_q  <= 1'b1;
                end
            end else if (state_q == SAFE) begin
                if (cnt_q == '0) begin
                    state_q <= ACTIVE;
                    out_q   <= dec_act;
                    busy_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

    assign bus.wso_wir = sr_q[0];
    assign bus.instr   = instr_q;
    assign bus.mux_sel = out_q.mux;
    assign bus.se      = out_q.se;
    assign bus.he      = out_q.he;
    assign bus.busy    = busy_q;
`ifdef WIR_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_wir_sel_ctrl.sv
// Self-checking bench for wir_sel_ctrl: directed vector table plus random run vs model.
// A second instance with SAFE_CYC=0 shares the stimulus.
module tb_wir_sel_ctrl;
    localparam int         NM   = 8;
    localparam int         WL   = 3;
    localparam int         SC   = 2;
    localparam logic [7:0] MASK = 8'h38;
`ifdef WIR_PARITY_EN
    localparam int L = WL + 1;
`else
    localparam int L = WL;
`endif

    logic clk = 1'b0;
    logic rst;

    wir_sel_ctrl_if #(.NUM_MUX(NM), .WIR_LEN(WL)) bus ();
    wir_sel_ctrl_if #(.NUM_MUX(NM), .WIR_LEN(WL)) bus0 ();

    wir_sel_ctrl #(.NUM_MUX(NM), .WIR_LEN(WL), .WPC_MASK(MASK), .SAFE_CYC(SC))
        dut (.clk(clk), .rst(rst), .bus(bus));
    wir_sel_ctrl #(.NUM_MUX(NM), .WIR_LEN(WL), .WPC_MASK(MASK), .SAFE_CYC(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    assign bus0.wsi        = bus.wsi;
    assign bus0.select_wir = bus.select_wir;
    assign bus0.capture_wr = bus.capture_wr;
    assign bus0.shift_wr   = bus.shift_wr;
    assign bus0.update_wr  = bus.update_wr;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: WIR as integer, active opcode, safe cycles remaining.
    int m_wir, m_instr, m_rem;
    bit m_perr;

    typedef struct {
        bit r, s, c, h, u, w;
        int instr;
        int mux;
        bit se, he, busy, wso;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int exp_mux(input int c);
        case (c)
            1:       return int'(MASK);
            2, 3:    return 'hFF;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_se(input int c);
        return (c == 1) || (c == 3);
    endfunction

    task automatic model_edge(input bit r, s, c, h, u, w);
        int op, old;
        bit upd, good;
        if (r) begin
            m_wir = 0; m_instr = 0; m_rem = 0; m_perr = 0;
            return;
        end
        old  = m_instr;
        upd  = s && u;
        op   = m_wir % (1 << WL);
        good = 1'b1;
`ifdef WIR_PARITY_EN
        good = ($countones(m_wir) % 2) == 1;
`endif
        m_perr = upd && !good;
        if (upd && good && op != m_instr) begin
            m_instr = op;
            m_rem   = SC;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (s && c) begin
            m_wir = old;
`ifdef WIR_PARITY_EN
            if ($countones(old) % 2 == 0) m_wir += (1 << WL);
`endif
        end else if (s && h) begin
            m_wir = (m_wir >> 1) | (int'(w) << (L - 1));
        end
    endtask

    task automatic drive(input bit r, s, c, h, u, w);
        rst            = r;
        bus.select_wir = s;
        bus.capture_wr = c;
        bus.shift_wr   = h;
        bus.update_wr  = u;
        bus.wsi        = w;
        @(posedge clk);
        model_edge(r, s, c, h, u, w);
        #1;
    endtask

    task automatic check_model(input string t);
        int cls;
        cls = (m_rem > 0) ? 0 : m_instr;
        chk({t, "_instr"}, int'(bus.instr), m_instr);
        chk({t, "_mux"}, int'(bus.mux_sel), exp_mux(cls));
        chk({t, "_se"}, int'(bus.se), int'(exp_se(cls)));
        chk({t, "_he"}, int'(bus.he), int'(!exp_se(cls)));
        chk({t, "_busy"}, int'(bus.busy), int'(m_rem > 0));
        chk({t, "_wso"}, int'(bus.wso_wir), m_wir % 2);
        chk({t, "_z_mux"}, int'(bus0.mux_sel), exp_mux(m_instr));
        chk({t, "_z_se"}, int'(bus0.se), int'(exp_se(m_instr)));
        chk({t, "_z_busy"}, int'(bus0.busy), 0);
`ifdef WIR_PARITY_EN
        chk({t, "_perr"}, int'(bus.parity_err), int'(m_perr));
`endif
    endtask

    task automatic shift_bits(input int val, input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, 0, 1, 0, val[i]);
            check_model("shift");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // r s c h u w | instr mux se he busy wso
        tv.push_back('{1,0,0,0,0,0, 0,'h00,0,1,0,0});
        tv.push_back('{1,0,0,0,0,0, 0,'h00,0,1,0,0});
        tv.push_back('{0,1,0,1,0,1, 0,'h00,0,1,0,0});
        tv.push_back('{0,1,0,1,0,1, 0,'h00,0,1,0,0});
        tv.push_back('{0,1,0,1,0,0, 0,'h00,0,1,0,1});
        tv.push_back('{0,1,0,0,1,0, 3,'h00,0,1,1,1});
        tv.push_back('{0,0,0,0,0,0, 3,'h00,0,1,1,1});
        tv.push_back('{0,0,0,0,0,0, 3,'hFF,1,0,0,1});
        tv.push_back('{0,1,0,1,0,1, 3,'hFF,1,0,0,1});
        tv.push_back('{0,1,0,1,0,0, 3,'hFF,1,0,0,0});
        tv.push_back('{0,1,0,1,0,0, 3,'hFF,1,0,0,1});
        tv.push_back('{0,1,0,0,1,0, 1,'h00,0,1,1,1});
        tv.push_back('{0,0,0,0,0,0, 1,'h00,0,1,1,1});
        tv.push_back('{0,0,0,0,0,0, 1,'h38,1,0,0,1});
        tv.push_back('{0,1,0,0,1,0, 1,'h38,1,0,0,1});
        tv.push_back('{0,0,0,0,0,0, 1,'h38,1,0,0,1});
        tv.push_back('{0,1,0,1,0,0, 1,'h38,1,0,0,0});
        tv.push_back('{0,1,0,1,0,1, 1,'h38,1,0,0,0});
        tv.push_back('{0,1,0,1,0,1, 1,'h38,1,0,0,0});
        tv.push_back('{0,1,0,0,1,0, 6,'h00,0,1,1,0});
        tv.push_back('{0,0,0,0,0,0, 6,'h00,0,1,1,0});
        tv.push_back('{0,0,0,0,0,0, 6,'h00,0,1,0,0});
        tv.push_back('{0,1,1,0,0,0, 6,'h00,0,1,0,0});
        tv.push_back('{0,1,0,1,0,0, 6,'h00,0,1,0,1});
        tv.push_back('{0,1,0,1,0,0, 6,'h00,0,1,0,1});
        tv.push_back('{0,1,0,1,0,0, 6,'h00,0,1,0,0});
        tv.push_back('{0,1,1,1,0,1, 6,'h00,0,1,0,0});
        tv.push_back('{0,1,0,1,0,0, 6,'h00,0,1,0,1});
        tv.push_back('{0,0,0,1,1,1, 6,'h00,0,1,0,1});
        tv.push_back('{0,1,0,1,0,1, 6,'h00,0,1,0,1});
        tv.push_back('{0,1,0,1,0,1, 6,'h00,0,1,0,0});
        tv.push_back('{0,1,0,1,0,1, 6,'h00,0,1,0,1});
        tv.push_back('{0,1,0,1,1,0, 7,'h00,0,1,1,1});
        tv.push_back('{0,1,0,0,1,0, 3,'h00,0,1,1,1});
        tv.push_back('{0,0,0,0,0,0, 3,'h00,0,1,1,1});
        tv.push_back('{0,0,0,0,0,0, 3,'hFF,1,0,0,1});
        tv.push_back('{0,1,0,1,0,0, 3,'hFF,1,0,0,1});
        tv.push_back('{0,1,0,1,0,1, 3,'hFF,1,0,0,0});
        tv.push_back('{0,1,0,1,0,0, 3,'hFF,1,0,0,0});
        tv.push_back('{0,1,0,0,1,0, 2,'h00,0,1,1,0});
        tv.push_back('{0,0,0,0,0,0, 2,'h00,0,1,1,0});
        tv.push_back('{0,0,0,0,0,0, 2,'hFF,0,1,0,0});
        tv.push_back('{0,1,0,1,0,1, 2,'hFF,0,1,0,1});
        tv.push_back('{0,1,0,0,1,0, 5,'h00,0,1,1,1});
        tv.push_back('{1,1,0,0,1,0, 0,'h00,0,1,0,0});
        tv.push_back('{0,0,0,0,0,0, 0,'h00,0,1,0,0});

`ifndef WIR_PARITY_EN
        foreach (tv[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tv[i].r, tv[i].s, tv[i].c, tv[i].h, tv[i].u, tv[i].w);
            chk({t, "_instr"}, int'(bus.instr), tv[i].instr);
            chk({t, "_mux"}, int'(bus.mux_sel), tv[i].mux);
            chk({t, "_se"}, int'(bus.se), int'(tv[i].se));
            chk({t, "_he"}, int'(bus.he), int'(tv[i].he));
            chk({t, "_busy"}, int'(bus.busy), int'(tv[i].busy));
            chk({t, "_wso"}, int'(bus.wso_wir), int'(tv[i].wso));
        end
`else
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check_model("p_rst");
        // opcode 2 with a wrong parity bit
        shift_bits('b1010, 4);
        drive(0, 1, 0, 0, 1, 0);
        check_model("p_bad");
        chk("p_bad_perr", int'(bus.parity_err), 1);
        chk("p_bad_instr", int'(bus.instr), 0);
        chk("p_bad_busy", int'(bus.busy), 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("p_perr_clr", int'(bus.parity_err), 0);
        shift_bits('b0010, 4);
        drive(0, 1, 0, 0, 1, 0);
        check_model("p_good");
        chk("p_good_busy", int'(bus.busy), 1);
        chk("p_good_instr", int'(bus.instr), 2);
        drive(1, 1, 0, 0, 1, 0);
        check_model("p_rst_safe");
        chk("p_rst_he", int'(bus.he), 1);
        drive(0, 1, 1, 0, 0, 0);
        check_model("p_cap");
        chk("p_cap_wso", int'(bus.wso_wir), 0);
`endif

        for (int k = 0; k < 800; k++) begin
            bit r, s, c, h, u, w;
            r = ($urandom_range(63) == 0);
            s = ($urandom_range(3) != 0);
            c = ($urandom_range(7) == 0);
            h = 1'($urandom_range(1));
            u = ($urandom_range(5) == 0);
            w = 1'($urandom_range(1));
            drive(r, s, c, h, u, w);
            check_model($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
